// File: rtl/odesa_neuron_integrate.sv
// Integrate-and-fire membrane stage fed by the 8-input CSA adder.
// Accumulates each accepted weighted sum into a saturating potential, fires a
// one-cycle spike when the potential reaches the threshold, then clears the
// potential and holds off for a fixed refractory period.
// Optional feature: define NEURON_LEAK_EN to include the tick-driven
// multiplicative leak (pot -= pot >> p_decay_shift). Without it the leak
// strobe is ignored and no leak logic exists.
module odesa_neuron_integrate #(
  parameter int unsigned p_sum_width     = 17,
  parameter int unsigned p_pot_width     = 20,
  parameter int unsigned p_refrac_cycles = 8,
  parameter int unsigned p_decay_shift   = 3
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic [p_sum_width-1:0] i_sum,
  input  logic                   i_valid,
  output logic                   o_ready,
  input  logic [p_pot_width-1:0] i_threshold,
  input  logic                   i_leak_tick,
  output logic                   o_spike,
  output logic [p_pot_width-1:0] o_potential,
  output logic                   o_refrac
);

  // The potential must be able to hold any single sum without truncation.
  if (p_pot_width < p_sum_width) begin : g_bad_width
    $error("odesa_neuron_integrate: p_pot_width must be >= p_sum_width");
  end

  // Counter wide enough to hold p_refrac_cycles; at least one bit.
  localparam int unsigned CntW =
      (p_refrac_cycles > 0) ? $clog2(p_refrac_cycles + 1) : 1;
  localparam logic [CntW-1:0] RefracLoad = CntW'(p_refrac_cycles);
  localparam logic            HasRefrac  = (p_refrac_cycles != 0);
  localparam int unsigned     ExtW       = p_pot_width + 1;

  typedef enum logic [2:0] {
    StIdle,
    StAcc,
    StCmp,
    StFire,
    StRefrac
  } state_e;

  state_e                 state_q, state_d;
  logic [p_pot_width-1:0] pot_q, pot_d;
  logic [p_sum_width-1:0] sum_q, sum_d;
  logic [CntW-1:0]        cnt_q, cnt_d;
  logic                   ready_q, ready_d;
  logic                   spike_q, spike_d;
  logic                   refrac_q, refrac_d;

  logic                   transfer;
  logic [ExtW-1:0]        acc_ext;
  logic [p_pot_width-1:0] acc_sat;

  assign transfer = i_valid & ready_q;

  // Zero-extended add with one carry bit; a carry means clamp to all ones.
  assign acc_ext = {1'b0, pot_q} + {{(ExtW - p_sum_width){1'b0}}, sum_q};
  assign acc_sat = acc_ext[ExtW-1] ? {p_pot_width{1'b1}} : acc_ext[p_pot_width-1:0];

`ifdef NEURON_LEAK_EN
  logic                   leak_pend_q, leak_pend_d;
  logic [p_pot_width-1:0] leak_val;

  assign leak_val = pot_q - (pot_q >> p_decay_shift);

  // Leak request flag: set by ticks outside FIRE/REFRAC, consumed by an
  // idle cycle without a transfer, dropped on fire.
  always_comb begin
    leak_pend_d = leak_pend_q;
    if (state_q == StFire || state_q == StRefrac) begin
      leak_pend_d = 1'b0;
    end else if (state_q == StIdle && !transfer && leak_pend_q) begin
      // Leak is applied this cycle; a coincident tick collapses into it.
      leak_pend_d = 1'b0;
    end else begin
      leak_pend_d = leak_pend_q | i_leak_tick;
    end
  end

  // Leak pending register.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      leak_pend_q <= 1'b0;
    end else begin
      leak_pend_q <= leak_pend_d;
    end
  end
`else
  logic unused_leak_tick;
  assign unused_leak_tick = i_leak_tick;
`endif

  // Next-state, datapath and registered-output decode.
  always_comb begin
    state_d = state_q;
    pot_d   = pot_q;
    sum_d   = sum_q;
    cnt_d   = cnt_q;

    unique case (state_q)
      StIdle: begin
        if (transfer) begin
          sum_d   = i_sum;
          state_d = StAcc;
        end
`ifdef NEURON_LEAK_EN
        else if (leak_pend_q) begin
          pot_d = leak_val;
        end
`endif
      end
      StAcc: begin
        pot_d   = acc_sat;
        state_d = StCmp;
      end
      StCmp: begin
        state_d = (pot_q >= i_threshold) ? StFire : StIdle;
      end
      StFire: begin
        pot_d   = '0;
        cnt_d   = RefracLoad;
        state_d = HasRefrac ? StRefrac : StIdle;
      end
      StRefrac: begin
        // Transfers accepted here are simply dropped.
        cnt_d = cnt_q - 1'b1;
        if (cnt_q <= 1) begin
          cnt_d   = '0;
          state_d = StIdle;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    // Outputs are registered, so they are decoded from the next state.
    ready_d  = (state_d == StIdle) || (state_d == StRefrac);
    spike_d  = (state_d == StFire);
    refrac_d = (state_d == StRefrac);
  end

  // State, datapath and output registers.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q  <= StIdle;
      pot_q    <= '0;
      sum_q    <= '0;
      cnt_q    <= '0;
      ready_q  <= 1'b0;
      spike_q  <= 1'b0;
      refrac_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      pot_q    <= pot_d;
      sum_q    <= sum_d;
      cnt_q    <= cnt_d;
      ready_q  <= ready_d;
      spike_q  <= spike_d;
      refrac_q <= refrac_d;
    end
  end

  assign o_ready     = ready_q;
  assign o_spike     = spike_q;
  assign o_refrac    = refrac_q;
  assign o_potential = pot_q;

endmodule

// File: tb/tb_odesa_neuron_integrate.sv
// Directed self-checking bench for odesa_neuron_integrate.
module tb_odesa_neuron_integrate;

  logic        clk;
  logic        rst;
  logic [16:0] sum;
  logic        valid;
  logic        ready;
  logic [19:0] threshold;
  logic        leak_tick;
  logic        spike;
  logic [19:0] potential;
  logic        refrac;

  int checks = 0;
  int errors = 0;

  odesa_neuron_integrate #(
    .p_sum_width    (17),
    .p_pot_width    (20),
    .p_refrac_cycles(8),
    .p_decay_shift  (3)
  ) dut (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_sum      (sum),
    .i_valid    (valid),
    .o_ready    (ready),
    .i_threshold(threshold),
    .i_leak_tick(leak_tick),
    .o_spike    (spike),
    .o_potential(potential),
    .o_refrac   (refrac)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Present one sum for a single edge; returns in cycle 1 (accumulate).
  task automatic send(input logic [16:0] s);
    sum   = s;
    valid = 1'b1;
    tick();
    valid = 1'b0;
  endtask

  // Full non-firing transaction: returns back in idle (cycle 3).
  task automatic push(input logic [16:0] s);
    send(s);
    tick();
    tick();
  endtask

  int n_refrac;
  int pot_nonzero;

  initial begin
    rst       = 1'b1;
    sum       = '0;
    valid     = 1'b0;
    threshold = 20'd1000;
    leak_tick = 1'b0;
    n_refrac  = 0;
    pot_nonzero = 0;

    // Reset state
    #1;
    chk("rst_ready", ready, 0);
    chk("rst_pot", potential, 0);
    tick();
    tick();
    chk("rst_spike", spike, 0);
    chk("rst_refrac", refrac, 0);
    rst = 1'b0;
    chk("rel_ready_low", ready, 0);
    tick();
    chk("rel_ready_high", ready, 1);

    // Threshold 1000: 400, 400, 300
    send(17'd400);
    chk("acc_ready_low", ready, 0);
    tick();
    chk("pot_400", potential, 400);
    chk("no_spike_400", spike, 0);
    tick();
    chk("idle_after_400", ready, 1);
    send(17'd400);
    tick();
    chk("pot_800", potential, 800);
    tick();
    chk("no_spike_800", spike, 0);
    send(17'd300);
    tick();
    chk("pot_1100", potential, 1100);
    chk("no_spike_cmp", spike, 0);
    tick();
    chk("spike_1100", spike, 1);
    chk("fire_ready_low", ready, 0);
    tick();
    chk("pot_clear", potential, 0);
    chk("spike_one_cycle", spike, 0);
    chk("refrac_first", refrac, 1);
    chk("refrac_ready", ready, 1);

    // Refractory: sum 900 accepted and dropped; count refractory cycles
    sum   = 17'd900;
    valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (refrac) n_refrac++;
      if (potential != 0) pot_nonzero++;
      tick();
      valid = 1'b0;
    end
    chk("refrac_len", n_refrac, 8);
    chk("refrac_pot_zero", pot_nonzero, 0);
    chk("post_refrac_pot", potential, 0);
    chk("post_refrac_ready", ready, 1);

    // Saturation: reach 1048000, then add 131071
    threshold = 20'hFFFFF;
    for (int i = 0; i < 7; i++) push(17'd131071);
    push(17'd130503);
    chk("pot_1048000", potential, 1048000);
    send(17'd131071);
    tick();
    chk("pot_saturated", potential, 1048575);
    tick();
    chk("spike_at_max", spike, 1);
    for (int i = 0; i < 12; i++) tick();
    chk("sat_done_refrac", refrac, 0);
    chk("sat_done_pot", potential, 0);

    // Threshold 0: sum 0 still fires
    threshold = 20'd0;
    send(17'd0);
    tick();
    chk("thr0_pot", potential, 0);
    tick();
    chk("thr0_spike", spike, 1);
    for (int i = 0; i < 12; i++) tick();

    // Reset mid-accumulate with potential 500
    threshold = 20'd1000;
    push(17'd500);
    chk("pre_rst_pot", potential, 500);
    send(17'd10);
    rst = 1'b1;
    #1;
    chk("mid_rst_ready", ready, 0);
    chk("mid_rst_spike", spike, 0);
    chk("mid_rst_refrac", refrac, 0);
    chk("mid_rst_pot", potential, 0);
    tick();
    rst = 1'b0;
    chk("mid_rel_ready_low", ready, 0);
    tick();
    chk("mid_rel_ready_high", ready, 1);
    tick();
    chk("mid_rel_pot", potential, 0);

    // Leak behaviour
    threshold = 20'd2000;
    push(17'd1000);
    chk("leak_base", potential, 1000);
`ifdef NEURON_LEAK_EN
    leak_tick = 1'b1;
    tick();
    leak_tick = 1'b0;
    chk("leak_pending", potential, 1000);
    tick();
    chk("leak_875", potential, 875);
    tick();
    push(17'd125);
    chk("leak_back_1000", potential, 1000);
    sum       = 17'd100;
    valid     = 1'b1;
    leak_tick = 1'b1;
    tick();
    valid     = 1'b0;
    leak_tick = 1'b0;
    tick();
    chk("leak_xfer_first", potential, 1100);
    tick();
    chk("leak_idle_1100", potential, 1100);
    tick();
    chk("leak_963", potential, 963);
`else
    for (int i = 0; i < 10; i++) begin
      leak_tick = 1'b1;
      tick();
    end
    leak_tick = 1'b0;
    tick();
    tick();
    chk("noleak_pot", potential, 1000);
    push(17'd5);
    chk("noleak_acc", potential, 1005);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
